// File: rtl/fft_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft_pkg
// Description : Shared definitions for the radix-2 DIT FFT control path.
//               Holds the sequencer state encoding, point-count helpers and
//               the butterfly address / twiddle-index arithmetic. The
//               butterfly datapath uses the same functions for checking.
// Revision    : 1.0 - initial release
// ============================================================================
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_FIN   = 2'd3
    } fft_state_t;

    // N = 2**log2n
    function automatic int unsigned fft_points(input int unsigned log2n);
        return 32'd1 << log2n;
    endfunction

    // Butterflies per stage, N/2
    function automatic int unsigned fft_half_points(input int unsigned log2n);
        return fft_points(log2n) >> 1;
    endfunction

    // Upper butterfly address: a zero is inserted at bit position s of j.
    function automatic logic [31:0] bf_addr_a(input logic [31:0] j,
                                              input logic [31:0] s);
        logic [31:0] span;
        span = 32'd1 << s;
        return ((j >> s) << (s + 32'd1)) | (j & (span - 32'd1));
    endfunction

    // Lower butterfly address: partner of A, one span further.
    function automatic logic [31:0] bf_addr_b(input logic [31:0] j,
                                              input logic [31:0] s);
        return bf_addr_a(j, s) | (32'd1 << s);
    endfunction

    // Twiddle index k = (j mod span) scaled up to the N/2 grid.
    function automatic logic [31:0] bf_twiddle(input logic [31:0] j,
                                               input logic [31:0] s,
                                               input logic [31:0] log2n);
        logic [31:0] span;
        span = 32'd1 << s;
        return (j & (span - 32'd1)) << (log2n - 32'd1 - s);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft_addr_delay.sv
`default_nettype none
// ============================================================================
// Module      : fft_addr_delay
// Description : Enabled shift register carrying {valid, addr_a, addr_b}
//               through the butterfly pipeline so write-back addresses line
//               up with the butterfly results.
// Ports       : clk, rst_n     - clock, async active-low reset
//               i_en           - shift enable (low freezes the whole line)
//               i_valid/i_addr_* - entry pushed at the head
//               o_valid/o_addr_* - registered tail of the line
// Revision    : 1.0 - initial release
// ============================================================================
module fft_addr_delay #(
    parameter int DEPTH = 3,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_en,
    input  logic          i_valid,
    input  logic [AW-1:0] i_addr_a,
    input  logic [AW-1:0] i_addr_b,
    output logic          o_valid,
    output logic [AW-1:0] o_addr_a,
    output logic [AW-1:0] o_addr_b
);

    logic [DEPTH-1:0]         r_valid;
    logic [DEPTH-1:0][AW-1:0] r_addr_a;
    logic [DEPTH-1:0][AW-1:0] r_addr_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid  <= '0;
            r_addr_a <= '0;
            r_addr_b <= '0;
        end else if (i_en) begin
            r_valid[0]  <= i_valid;
            r_addr_a[0] <= i_addr_a;
            r_addr_b[0] <= i_addr_b;
            for (int i = 1; i < DEPTH; i++) begin
                r_valid[i]  <= r_valid[i-1];
                r_addr_a[i] <= r_addr_a[i-1];
                r_addr_b[i] <= r_addr_b[i-1];
            end
        end
    end

    assign o_valid  = r_valid[DEPTH-1];
    assign o_addr_a = r_addr_a[DEPTH-1];
    assign o_addr_b = r_addr_b[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/fft_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : fft_addr_gen
// Description : Address generator for an in-place radix-2 DIT FFT. Issues
//               one butterfly per active cycle (data RAM read addresses A/B
//               and twiddle ROM index), delays the addresses for write-back,
//               and inserts a drain gap between stages so a stage never reads
//               a location the previous stage has yet to write.
// Ports       : CLK, RST_n          - clock, async active-low reset
//               Start, Hold         - run request, global freeze
//               Busy, Done, Stage   - sequencing status
//               Rd_Valid/Rd_Addr_*  - butterfly read issue
//               Tw_Addr             - twiddle ROM address (zero-extended k)
//               Wr_Valid/Wr_Addr_*  - butterfly write-back
// Revision    : 1.0 - initial release
// ============================================================================
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int LOG2_NFFT  = 5,
    parameter int DATA_WIDTH = 16,
    parameter int BF_LATENCY = 3
) (
    input  logic                  CLK,
    input  logic                  RST_n,
    input  logic                  Start,
    input  logic                  Hold,
    output logic                  Busy,
    output logic                  Done,
    output logic [LOG2_NFFT-1:0]  Stage,
    output logic                  Rd_Valid,
    output logic [LOG2_NFFT-1:0]  Rd_Addr_A,
    output logic [LOG2_NFFT-1:0]  Rd_Addr_B,
    output logic [DATA_WIDTH-1:0] Tw_Addr,
    output logic                  Wr_Valid,
    output logic [LOG2_NFFT-1:0]  Wr_Addr_A,
    output logic [LOG2_NFFT-1:0]  Wr_Addr_B
);

    // j needs LOG2_NFFT-1 bits; keep at least one bit for the N=2 case.
    localparam int c_JW = (LOG2_NFFT > 1) ? LOG2_NFFT - 1 : 1;
    localparam int c_CW = $clog2(BF_LATENCY + 1);

    localparam logic [c_JW-1:0]      c_J_LAST     = c_JW'(fft_half_points(LOG2_NFFT) - 1);
    localparam logic [LOG2_NFFT-1:0] c_S_LAST     = LOG2_NFFT'(LOG2_NFFT - 1);
    localparam logic [c_CW-1:0]      c_DRAIN_LOAD = c_CW'(BF_LATENCY);
    localparam logic [c_CW-1:0]      c_DRAIN_LAST = c_CW'(1);

    fft_state_t           r_state;
    logic [c_JW-1:0]      r_j;
    logic [LOG2_NFFT-1:0] r_s;
    logic [c_CW-1:0]      r_drain;

    logic                  w_advance;
    logic                  w_reading;
    logic                  w_rd_valid;
    logic [LOG2_NFFT-1:0]  w_addr_a;
    logic [LOG2_NFFT-1:0]  w_addr_b;
    logic [DATA_WIDTH-1:0] w_tw;
    logic                  w_wr_valid_tail;

    assign w_advance = ~Hold;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_state <= ST_IDLE;
            r_j     <= '0;
            r_s     <= '0;
            r_drain <= '0;
        end else if (w_advance) begin
            case (r_state)
                ST_IDLE: begin
                    if (Start) begin
                        r_state <= ST_READ;
                        r_j     <= '0;
                        r_s     <= '0;
                    end
                end
                ST_READ: begin
                    if (r_j == c_J_LAST) begin
                        r_state <= ST_DRAIN;
                        r_drain <= c_DRAIN_LOAD;
                    end else begin
                        r_j <= r_j + 1'b1;
                    end
                end
                ST_DRAIN: begin
                    // Last drain cycle: the final write-back of this stage
                    // is on the write port now.
                    if (r_drain == c_DRAIN_LAST) begin
                        if (r_s < c_S_LAST) begin
                            r_s     <= r_s + 1'b1;
                            r_j     <= '0;
                            r_state <= ST_READ;
                        end else begin
                            r_state <= ST_FIN;
                        end
                    end else begin
                        r_drain <= r_drain - 1'b1;
                    end
                end
                ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_s     <= '0;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign w_reading  = (r_state == ST_READ);
    assign w_rd_valid = w_reading & w_advance;

    assign w_addr_a = LOG2_NFFT'(bf_addr_a(32'(r_j), 32'(r_s)));
    assign w_addr_b = LOG2_NFFT'(bf_addr_b(32'(r_j), 32'(r_s)));
    assign w_tw     = DATA_WIDTH'(bf_twiddle(32'(r_j), 32'(r_s), 32'(LOG2_NFFT)));

    fft_addr_delay #(
        .DEPTH (BF_LATENCY),
        .AW    (LOG2_NFFT)
    ) u_delay (
        .clk      (CLK),
        .rst_n    (RST_n),
        .i_en     (w_advance),
        .i_valid  (w_reading),
        .i_addr_a (w_addr_a),
        .i_addr_b (w_addr_b),
        .o_valid  (w_wr_valid_tail),
        .o_addr_a (Wr_Addr_A),
        .o_addr_b (Wr_Addr_B)
    );

    assign Busy      = (r_state != ST_IDLE);
    assign Done      = (r_state == ST_FIN) & w_advance;
    assign Stage     = r_s;
    assign Rd_Valid  = w_rd_valid;
    assign Rd_Addr_A = w_rd_valid ? w_addr_a : '0;
    assign Rd_Addr_B = w_rd_valid ? w_addr_b : '0;
    assign Tw_Addr   = w_rd_valid ? w_tw     : '0;
    assign Wr_Valid  = w_wr_valid_tail & w_advance;

endmodule
`default_nettype wire

// File: tb/tb_fft_addr_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_fft_addr_gen
// Description : Directed self-checking bench for fft_addr_gen. Main DUT is
//               N=8 / BF_LATENCY=2; a second instance covers N=2 /
//               BF_LATENCY=1. Inputs change on the falling edge, outputs are
//               sampled 1 time unit later.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_addr_gen;

    localparam int LG = 3;
    localparam int DW = 16;
    localparam int BL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n, start, hold;
    logic          busy, done, rv, wv;
    logic [LG-1:0] stage, ra, rb, wa, wb;
    logic [DW-1:0] tw;

    logic          start1, hold1;
    logic          busy1, done1, rv1, wv1;
    logic [0:0]    stage1, ra1, rb1, wa1, wb1;
    logic [DW-1:0] tw1;

    fft_addr_gen #(.LOG2_NFFT(LG), .DATA_WIDTH(DW), .BF_LATENCY(BL)) u_dut (
        .CLK(clk), .RST_n(rst_n), .Start(start), .Hold(hold),
        .Busy(busy), .Done(done), .Stage(stage),
        .Rd_Valid(rv), .Rd_Addr_A(ra), .Rd_Addr_B(rb), .Tw_Addr(tw),
        .Wr_Valid(wv), .Wr_Addr_A(wa), .Wr_Addr_B(wb)
    );

    fft_addr_gen #(.LOG2_NFFT(1), .DATA_WIDTH(DW), .BF_LATENCY(1)) u_dut_small (
        .CLK(clk), .RST_n(rst_n), .Start(start1), .Hold(hold1),
        .Busy(busy1), .Done(done1), .Stage(stage1),
        .Rd_Valid(rv1), .Rd_Addr_A(ra1), .Rd_Addr_B(rb1), .Tw_Addr(tw1),
        .Wr_Valid(wv1), .Wr_Addr_A(wa1), .Wr_Addr_B(wb1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic          busy;
        logic          done;
        logic [LG-1:0] stage;
        logic          rv;
        logic [LG-1:0] ra;
        logic [LG-1:0] rb;
        logic [DW-1:0] tw;
        logic          wv;
        logic [LG-1:0] wa;
        logic [LG-1:0] wb;
    } obs_t;

    // Hand-computed butterflies for N=8, in issue order (stage 0, 1, 2).
    int tbl_a [12] = '{0, 2, 4, 6,  0, 1, 4, 5,  0, 1, 2, 3};
    int tbl_b [12] = '{1, 3, 5, 7,  2, 3, 6, 7,  4, 5, 6, 7};
    int tbl_k [12] = '{0, 0, 0, 0,  0, 2, 0, 2,  0, 1, 2, 3};

    function automatic obs_t sample();
        return {busy, done, stage, rv, ra, rb, tw, wv, wa, wb};
    endfunction

    function automatic string fmt(input obs_t o);
        return $sformatf("busy=%0b done=%0b stage=%0d rv=%0b a=%0d b=%0d tw=%0d wv=%0b wa=%0d wb=%0d",
                         o.busy, o.done, o.stage, o.rv, o.ra, o.rb, o.tw, o.wv, o.wa, o.wb);
    endfunction

    // Expected outputs at active cycle a of an N=8, BF_LATENCY=2 run
    // (a=0: idle; reads 1-4, 7-10, 13-16; drains of 2; Done at 19).
    // Write addresses are don't-care while Wr_Valid is low.
    function automatic void exp_at(input int a, output obs_t e, output obs_t m);
        int idx, w;
        e = '0;
        m = '1;
        if (a >= 1 && a <= 19) e.busy = 1'b1;
        if (a == 19) e.done = 1'b1;
        if (a >= 1 && a <= 18) e.stage = 3'((a - 1) / 6);
        if (a == 19) m.stage = '0;
        if (a >= 1 && a <= 18 && ((a - 1) % 6) < 4) begin
            idx  = ((a - 1) / 6) * 4 + ((a - 1) % 6);
            e.rv = 1'b1;
            e.ra = 3'(tbl_a[idx]);
            e.rb = 3'(tbl_b[idx]);
            e.tw = 16'(tbl_k[idx]);
        end
        w = a - BL;
        if (w >= 1 && w <= 18 && ((w - 1) % 6) < 4) begin
            idx  = ((w - 1) / 6) * 4 + ((w - 1) % 6);
            e.wv = 1'b1;
            e.wa = 3'(tbl_a[idx]);
            e.wb = 3'(tbl_b[idx]);
        end else begin
            m.wa = '0;
            m.wb = '0;
        end
    endfunction

    task automatic test_reset();
        obs_t o;
        logic [22:0] s;
        rst_n = 1'b0; start = 1'b0; hold = 1'b0; start1 = 1'b0; hold1 = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        o = sample();
        n_checks++;
        if (o !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %s, expected all zero", fmt(o));
        end
        s = {busy1, done1, stage1, rv1, ra1, rb1, tw1, wv1, wa1, wb1};
        n_checks++;
        if (s !== '0) begin
            n_fail++;
            $display("FAIL reset_state_small: got %h, expected 0", s);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            obs_t e, m;
            @(negedge clk);
            #1;
            exp_at(0, e, m);
            o = sample();
            n_checks++;
            if (((o ^ e) & m) !== '0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got %s, expected %s", c, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_nominal();
        obs_t e, m, o;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 22; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            exp_at(cyc, e, m);
            o = sample();
            n_checks++;
            if (((o ^ e) & m) !== '0) begin
                n_fail++;
                $display("FAIL nominal cycle %0d: got %s, expected %s", cyc, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_hold();
        obs_t e, m, o;
        int a = 0;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 25; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            hold  = (cyc >= 3 && cyc <= 5);
            #1;
            if (hold) begin
                exp_at(a + 1, e, m);
                e.rv = 1'b0; e.ra = '0; e.rb = '0; e.tw = '0;
                e.wv = 1'b0; e.done = 1'b0;
                m.wa = '0;   m.wb = '0;
            end else begin
                a++;
                exp_at(a, e, m);
            end
            o = sample();
            n_checks++;
            if (((o ^ e) & m) !== '0) begin
                n_fail++;
                $display("FAIL hold cycle %0d: got %s, expected %s", cyc, fmt(o), fmt(e));
            end
        end
        hold = 1'b0;
    endtask

    task automatic test_start_ignored();
        obs_t e, m, o;
        @(negedge clk);
        start = 1'b1;
        hold  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        hold  = 1'b0;
        for (int c = 0; c < 2; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            exp_at(0, e, m);
            o = sample();
            n_checks++;
            if (((o ^ e) & m) !== '0) begin
                n_fail++;
                $display("FAIL start_with_hold cycle %0d: got %s, expected %s", c, fmt(o), fmt(e));
            end
        end
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 21; cyc++) begin
            @(negedge clk);
            start = (cyc == 8);
            #1;
            exp_at(cyc, e, m);
            o = sample();
            n_checks++;
            if (((o ^ e) & m) !== '0) begin
                n_fail++;
                $display("FAIL start_while_busy cycle %0d: got %s, expected %s", cyc, fmt(o), fmt(e));
            end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_midrun();
        obs_t e, m, o;
        @(negedge clk);
        start = 1'b1;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            #1;
            exp_at(cyc, e, m);
            o = sample();
            n_checks++;
            if (((o ^ e) & m) !== '0) begin
                n_fail++;
                $display("FAIL midrun_pre cycle %0d: got %s, expected %s", cyc, fmt(o), fmt(e));
            end
        end
        #1;
        rst_n = 1'b0;
        #1;
        o = sample();
        n_checks++;
        if (o !== '0) begin
            n_fail++;
            $display("FAIL midrun_async_reset: got %s, expected all zero", fmt(o));
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            exp_at(0, e, m);
            o = sample();
            n_checks++;
            if (((o ^ e) & m) !== '0) begin
                n_fail++;
                $display("FAIL midrun_stays_idle cycle %0d: got %s, expected %s", c, fmt(o), fmt(e));
            end
        end
    endtask

    task automatic test_small();
        // {busy, done, stage, rv, ra, rb, wv} per cycle 1..4, Tw always 0
        logic [6:0] exp_t [4] = '{7'b1_0_0_1_0_1_0, 7'b1_0_0_0_0_0_1,
                                  7'b1_1_0_0_0_0_0, 7'b0_0_0_0_0_0_0};
        logic [22:0] got, exp;
        @(negedge clk);
        start1 = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge clk);
            start1 = 1'b0;
            #1;
            got = {busy1, done1, stage1, rv1, ra1, rb1, wv1, tw1};
            exp = {exp_t[cyc-1], 16'd0};
            n_checks++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL small cycle %0d: got %h, expected %h", cyc, got, exp);
            end
            if (exp_t[cyc-1][0]) begin
                n_checks++;
                if ({wa1, wb1} !== 2'b01) begin
                    n_fail++;
                    $display("FAIL small_wr_addr cycle %0d: got %b, expected 01", cyc, {wa1, wb1});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_hold();
        test_start_ignored();
        test_reset_midrun();
        test_small();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
